// File: rtl/piso_frame_tx_pkg.sv
// rtl/piso_frame_tx_pkg.sv - shared array dimensions, FSM state type and counter sizing helper
package piso_frame_tx_pkg;

    localparam int array_width_p  = 2;
    localparam int array_height_p = 2;
    localparam int width_default  = 1;
    localparam int depth_default  = 8;
    localparam int words_default  = array_width_p * array_height_p;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // A counter over n values still needs one bit when n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_frame_tx.sv
// rtl/piso_frame_tx.sv - parallel-in/serial-out word transmitter with word and frame markers
module piso_frame_tx
    import piso_frame_tx_pkg::*;
#(
    parameter int width_p = width_default,
    parameter int depth_p = depth_default,
    parameter int words_p = words_default
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       ready_o,
    input  logic                       valid_i,
    input  logic [width_p*depth_p-1:0] data_i,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic                       word_last_o,
    output logic                       frame_last_o
);

    localparam int word_w     = width_p * depth_p;
    localparam int beat_cnt_w = cnt_width(depth_p);
    localparam int word_cnt_w = cnt_width(words_p);

    localparam logic [beat_cnt_w-1:0] beat_last_idx = beat_cnt_w'(depth_p - 1);
    localparam logic [word_cnt_w-1:0] word_last_idx = word_cnt_w'(words_p - 1);

    piso_state_e             state_r;
    piso_state_e             state_n;
    logic [word_w-1:0]       shift_r;
    logic [beat_cnt_w-1:0]   beat_cnt_r;
    logic [word_cnt_w-1:0]   word_cnt_r;

    logic load;
    logic consume;
    logic last_consume;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Reset forces every output low, including ready_o, regardless of state.
    always_comb begin
        state_n      = state_r;
        ready_o      = 1'b0;
        valid_o      = 1'b0;
        data_o       = '0;
        word_last_o  = 1'b0;
        frame_last_o = 1'b0;
        load         = 1'b0;
        consume      = 1'b0;
        last_consume = 1'b0;
        if (!reset_i) begin
            case (state_r)
                IDLE: begin
                    ready_o = 1'b1;
                    load    = valid_i;
                    if (valid_i) begin
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    valid_o      = 1'b1;
                    data_o       = shift_r[word_w-1 -: width_p];
                    word_last_o  = (beat_cnt_r == beat_last_idx);
                    frame_last_o = (word_cnt_r == word_last_idx);
                    consume      = yumi_i;
                    // Taking the final beat frees the register in the same cycle,
                    // so a waiting word is loaded with no bubble.
                    if (yumi_i && word_last_o) begin
                        ready_o      = 1'b1;
                        last_consume = 1'b1;
                        load         = valid_i;
                        state_n      = valid_i ? SHIFT : IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_r    <= '0;
            beat_cnt_r <= '0;
            word_cnt_r <= '0;
        end else begin
            if (load) begin
                shift_r    <= data_i;
                beat_cnt_r <= '0;
            end else if (consume) begin
                shift_r    <= shift_r << width_p;
                beat_cnt_r <= beat_cnt_r + beat_cnt_w'(1);
            end
            if (last_consume) begin
                word_cnt_r <= (word_cnt_r == word_last_idx) ? '0
                                                            : word_cnt_r + word_cnt_w'(1);
            end
        end
    end

endmodule
